// File: rtl/port_cfg_ctrl.sv
// port_cfg_ctrl: per-ID port ACL table and destination-port CAM with packet-safe deferred writes.
// Latency: reads are combinational; an unblocked write commits 1 cycle after acceptance, response 1 cycle later.
// Backpressure: one write outstanding; cfg_wr_ready is low from acceptance through the response cycle; monitor never stalls.
//
// Ports:
//   aclk / aresetn          clock, asynchronous active-low reset
//   mon_*                   parser input stream beat monitor (tid, tvalid, tready, tlast)
//   port_config_sel         {tid, tdest} lookup select; port_config_regs = table[sel]
//   port_cam_values         CAM entry i at [17*i +: 17]
//   cfg_wr_*                software write request (valid/ready), sel, type (0 table, 1 CAM), data
//   cfg_wr_resp_valid       one-cycle commit pulse; cfg_wr_resp_forced marks a timeout commit
module port_cfg_ctrl #(
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 0,
  parameter int WAIT_TIMEOUT    = 1024,
  localparam int NUM_ID = 2 ** AXIS_ID_WIDTH,
  localparam int ID_W   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int DEST_W = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
  localparam int SEL_W  = ID_W + DEST_W
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_W-1:0]       mon_tid,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  input  logic [SEL_W-1:0]      port_config_sel,
  output logic [33:0]           port_config_regs,
  output logic [17*NUM_ID-1:0]  port_cam_values,
  input  logic                  cfg_wr_valid,
  output logic                  cfg_wr_ready,
  input  logic [SEL_W-1:0]      cfg_wr_sel,
  input  logic                  cfg_wr_type,
  input  logic [33:0]           cfg_wr_data,
  output logic                  cfg_wr_resp_valid,
  output logic                  cfg_wr_resp_forced
);

  // Storage is sized by the physical select/ID widths so every index value is in range,
  // even when a zero-width stream field is widened to one bit.
  localparam int TABLE_DEPTH = 2 ** SEL_W;
  localparam int NUM_IDX     = 2 ** ID_W;
  localparam int CNT_W       = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                forced_q, forced_nxt;
  logic                latch_req;
  logic                commit;

  logic [SEL_W-1:0]    req_sel;
  logic                req_type;
  logic [33:0]         req_data;
  logic [ID_W-1:0]     req_id;

  logic [NUM_IDX-1:0]  inflight;
  logic                mon_hs;
  logic                blocked;

  logic [33:0]         cfg_table [TABLE_DEPTH];
  logic [16:0]         cam       [NUM_IDX];

  assign mon_hs = mon_tvalid & mon_tready;
  assign req_id = req_sel[SEL_W-1:DEST_W];

  // A beat on the target ID in the same cycle also blocks, so a packet that
  // starts while the write is waiting cannot be split by the update.
  assign blocked = inflight[req_id] | (mon_hs & (mon_tid == req_id));

  // Packet-open flag per ID: set on a non-last beat, cleared by the last beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight <= '0;
    end else if (mon_hs) begin
      inflight[mon_tid] <= ~mon_tlast;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      forced_q <= forced_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_sel  <= '0;
      req_type <= 1'b0;
      req_data <= '0;
    end else if (latch_req) begin
      req_sel  <= cfg_wr_sel;
      req_type <= cfg_wr_type;
      req_data <= cfg_wr_data;
    end
  end

  always_comb begin
    state_nxt          = state_q;
    cnt_nxt            = cnt_q;
    forced_nxt         = forced_q;
    latch_req          = 1'b0;
    commit             = 1'b0;
    cfg_wr_ready       = 1'b0;
    cfg_wr_resp_valid  = 1'b0;
    cfg_wr_resp_forced = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_wr_ready = 1'b1;
        if (cfg_wr_valid) begin
          latch_req = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!blocked) begin
          commit     = 1'b1;
          forced_nxt = 1'b0;
          state_nxt  = ST_RESP;
        end else if ((WAIT_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          commit     = 1'b1;
          forced_nxt = 1'b1;
          state_nxt  = ST_RESP;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          // Saturate: with an unlimited wait the counter must not wrap.
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        cfg_wr_resp_valid  = 1'b1;
        cfg_wr_resp_forced = forced_q;
        state_nxt          = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < TABLE_DEPTH; i++) cfg_table[i] <= '0;
    end else if (commit && !req_type) begin
      cfg_table[req_sel] <= req_data;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_IDX; i++) cam[i] <= '0;
    end else if (commit && req_type) begin
      cam[req_id] <= req_data[16:0];
    end
  end

  assign port_config_regs = cfg_table[port_config_sel];

  always_comb begin
    port_cam_values = '0;
    for (int i = 0; i < NUM_ID; i++) port_cam_values[17*i +: 17] = cam[i];
  end

endmodule

// File: tb/tb_port_cfg_ctrl.sv
// tb_port_cfg_ctrl: directed timing scenarios plus randomized traffic against a per-cycle reference model.
module tb_port_cfg_ctrl;
  localparam int TO     = 16;
  localparam int NUM_ID = 16;

  logic         aclk;
  logic         aresetn;
  logic [3:0]   mon_tid;
  logic         mon_tvalid, mon_tready, mon_tlast;
  logic [4:0]   port_config_sel;
  logic [33:0]  port_config_regs;
  logic [271:0] port_cam_values;
  logic         cfg_wr_valid, cfg_wr_ready;
  logic [4:0]   cfg_wr_sel;
  logic         cfg_wr_type;
  logic [33:0]  cfg_wr_data;
  logic         cfg_wr_resp_valid, cfg_wr_resp_forced;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: storage contents, open packets per ID, and the pending write.
  logic [33:0] m_table [32];
  logic [16:0] m_cam   [NUM_ID];
  bit          m_open  [NUM_ID];
  bit          m_pend, m_resp, m_forced;
  int          m_k;
  logic [4:0]  m_sel;
  bit          m_type;
  logic [33:0] m_data;

  port_cfg_ctrl #(.AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(0), .WAIT_TIMEOUT(TO)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .mon_tid            (mon_tid),
    .mon_tvalid         (mon_tvalid),
    .mon_tready         (mon_tready),
    .mon_tlast          (mon_tlast),
    .port_config_sel    (port_config_sel),
    .port_config_regs   (port_config_regs),
    .port_cam_values    (port_cam_values),
    .cfg_wr_valid       (cfg_wr_valid),
    .cfg_wr_ready       (cfg_wr_ready),
    .cfg_wr_sel         (cfg_wr_sel),
    .cfg_wr_type        (cfg_wr_type),
    .cfg_wr_data        (cfg_wr_data),
    .cfg_wr_resp_valid  (cfg_wr_resp_valid),
    .cfg_wr_resp_forced (cfg_wr_resp_forced)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_table[i] = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      m_cam[i]  = '0;
      m_open[i] = 1'b0;
    end
    m_pend = 0; m_resp = 0; m_forced = 0; m_k = 0;
  endtask

  // A write waits until its ID has no open packet and no beat this cycle,
  // or until it has spent TO cycles waiting; the response follows one cycle later.
  task automatic model_edge();
    bit hs, busy;
    int t;
    hs = mon_tvalid && mon_tready;
    if (m_resp) begin
      m_resp = 0;
    end else if (m_pend) begin
      m_k++;
      t = int'(m_sel[4:1]);
      busy = m_open[t] || (hs && int'(mon_tid) == t);
      if (!busy || m_k == TO) begin
        if (m_type) m_cam[t] = m_data[16:0];
        else        m_table[m_sel] = m_data;
        m_forced = busy;
        m_pend   = 0;
        m_resp   = 1;
      end
    end else if (cfg_wr_valid) begin
      m_sel = cfg_wr_sel; m_type = cfg_wr_type; m_data = cfg_wr_data;
      m_pend = 1; m_k = 0;
    end
    if (hs) m_open[mon_tid] = !mon_tlast;
  endtask

  function automatic logic [271:0] cam_pack();
    logic [271:0] v;
    v = '0;
    for (int i = 0; i < NUM_ID; i++) v[17*i +: 17] = m_cam[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge aclk);
    if (!aresetn) model_reset();
    else          model_edge();
    cyc++;
    #1;
  endtask

  task automatic mon_idle();
    mon_tvalid = 0; mon_tready = 1; mon_tlast = 0; mon_tid = '0;
  endtask

  task automatic beat(input int tid, input bit last);
    mon_tvalid = 1; mon_tready = 1; mon_tlast = last; mon_tid = 4'(tid);
  endtask

  task automatic request(input logic [4:0] sel, input bit typ, input logic [33:0] data);
    cfg_wr_valid = 1; cfg_wr_sel = sel; cfg_wr_type = typ; cfg_wr_data = data;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_wr_ready); end
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", cfg_wr_resp_valid); end
    checks++; if (cfg_wr_resp_forced !== 1'b0) begin errors++; $display("FAIL reset_forced: got %b expected 0", cfg_wr_resp_forced); end
    checks++; if (port_config_regs !== 34'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", port_config_regs); end
    checks++; if (port_cam_values !== 272'h0) begin errors++; $display("FAIL reset_cam: got %h expected 0", port_cam_values); end
    tick(); tick();
    aresetn = 1;
    tick();
    checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", cfg_wr_ready); end
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_resp: got %b expected 0", cfg_wr_resp_valid); end
  endtask

  task automatic test_unblocked();
    logic [33:0] d;
    d = 34'h1_0050_0016;
    mon_idle();
    request(5'd5, 1'b0, d);
    port_config_sel = 5'd5;
    #1;
    checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL unblk_ready_N: got %b expected 1", cfg_wr_ready); end
    tick(); cfg_wr_valid = 0;        // cycle N+1
    checks++; if (cfg_wr_ready !== 1'b0) begin errors++; $display("FAIL unblk_ready_N1: got %b expected 0", cfg_wr_ready); end
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL unblk_resp_N1: got %b expected 0", cfg_wr_resp_valid); end
    checks++; if (port_config_regs !== 34'h0) begin errors++; $display("FAIL unblk_regs_N1: got %h expected 0", port_config_regs); end
    tick();                           // cycle N+2
    checks++; if (cfg_wr_resp_valid !== 1'b1) begin errors++; $display("FAIL unblk_resp_N2: got %b expected 1", cfg_wr_resp_valid); end
    checks++; if (cfg_wr_resp_forced !== 1'b0) begin errors++; $display("FAIL unblk_forced_N2: got %b expected 0", cfg_wr_resp_forced); end
    checks++; if (port_config_regs !== d) begin errors++; $display("FAIL unblk_regs_N2: got %h expected %h", port_config_regs, d); end
    checks++; if (cfg_wr_ready !== 1'b0) begin errors++; $display("FAIL unblk_ready_N2: got %b expected 0", cfg_wr_ready); end
    tick();                           // cycle N+3
    checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL unblk_ready_N3: got %b expected 1", cfg_wr_ready); end
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL unblk_resp_N3: got %b expected 0", cfg_wr_resp_valid); end
    for (int s = 0; s < 32; s++) begin
      port_config_sel = 5'(s);
      tick();
      checks++;
      if (port_config_regs !== ((s == 5) ? d : 34'h0)) begin
        errors++; $display("FAIL unblk_sel_%0d: got %h expected %h", s, port_config_regs, (s == 5) ? d : 34'h0);
      end
    end
  endtask

  task automatic test_packet_block();
    logic [16:0] v;
    beat(2, 1'b0); tick(); mon_idle();
    request(5'd4, 1'b1, {17'h0_5A5A, 17'h1_01BB});
    tick(); cfg_wr_valid = 0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL pkt_early_resp_%0d: got %b expected 0", i, cfg_wr_resp_valid); end
      v = port_cam_values[50:34];
      checks++; if (v !== 17'h0) begin errors++; $display("FAIL pkt_early_cam_%0d: got %h expected 0", i, v); end
      tick();
    end
    beat(2, 1'b1);                    // cycle M: last beat
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL pkt_resp_M: got %b expected 0", cfg_wr_resp_valid); end
    tick(); mon_idle();               // M+1
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL pkt_resp_M1: got %b expected 0", cfg_wr_resp_valid); end
    tick();                           // M+2
    checks++; if (cfg_wr_resp_valid !== 1'b1) begin errors++; $display("FAIL pkt_resp_M2: got %b expected 1", cfg_wr_resp_valid); end
    checks++; if (cfg_wr_resp_forced !== 1'b0) begin errors++; $display("FAIL pkt_forced_M2: got %b expected 0", cfg_wr_resp_forced); end
    v = port_cam_values[50:34];
    checks++; if (v !== 17'h1_01BB) begin errors++; $display("FAIL pkt_cam2: got %h expected 101bb", v); end
    checks++; if (port_cam_values !== cam_pack()) begin errors++; $display("FAIL pkt_cam_all: got %h expected %h", port_cam_values, cam_pack()); end
    tick();
  endtask

  task automatic test_other_id();
    logic [33:0] d;
    d = 34'h2_1234_5678;
    beat(3, 1'b0); tick();
    request(5'd4, 1'b0, d);
    port_config_sel = 5'd4;
    tick(); cfg_wr_valid = 0;         // N+1, beat on tid 3 again
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL other_resp_N1: got %b expected 0", cfg_wr_resp_valid); end
    tick(); mon_idle();               // N+2
    checks++; if (cfg_wr_resp_valid !== 1'b1) begin errors++; $display("FAIL other_resp_N2: got %b expected 1", cfg_wr_resp_valid); end
    checks++; if (cfg_wr_resp_forced !== 1'b0) begin errors++; $display("FAIL other_forced: got %b expected 0", cfg_wr_resp_forced); end
    checks++; if (port_config_regs !== d) begin errors++; $display("FAIL other_regs: got %h expected %h", port_config_regs, d); end
    tick();
    beat(3, 1'b1); tick(); mon_idle(); tick();
  endtask

  task automatic test_timeout();
    logic [33:0] d;
    int n, lat;
    bit got, fr;
    d = 34'h3_0BAD_F00D;
    beat(1, 1'b0); tick(); mon_idle();
    request(5'd3, 1'b0, d);
    port_config_sel = 5'd3;
    n = cyc;
    tick(); cfg_wr_valid = 0;
    got = 0; lat = 0; fr = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (cfg_wr_resp_valid) begin
        got = 1; lat = cyc - n; fr = cfg_wr_resp_forced;
      end else begin
        if (i % 3 == 0) beat(1, 1'b0); else mon_idle();
        tick();
      end
    end
    mon_idle();
    checks++; if (!got) begin errors++; $display("FAIL timeout_seen: got no response expected one within 40 cycles"); end
    checks++; if (lat !== TO + 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TO + 1); end
    checks++; if (fr !== 1'b1) begin errors++; $display("FAIL timeout_forced: got %b expected 1", fr); end
    checks++; if (port_config_regs !== d) begin errors++; $display("FAIL timeout_regs: got %h expected %h", port_config_regs, d); end
    tick();
    beat(1, 1'b1); tick(); mon_idle(); tick();
  endtask

  task automatic test_sop_collision();
    logic [16:0] v;
    mon_idle();
    request(5'd8, 1'b1, 34'h1_1234);
    tick(); cfg_wr_valid = 0;         // N+1: first WAIT cycle
    beat(4, 1'b0);
    tick(); mon_idle();               // N+2
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL sop_resp_N2: got %b expected 0", cfg_wr_resp_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL sop_resp_wait_%0d: got %b expected 0", i, cfg_wr_resp_valid); end
    end
    beat(4, 1'b1);                    // M
    tick(); mon_idle();               // M+1
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL sop_resp_M1: got %b expected 0", cfg_wr_resp_valid); end
    tick();                           // M+2
    checks++; if (cfg_wr_resp_valid !== 1'b1) begin errors++; $display("FAIL sop_resp_M2: got %b expected 1", cfg_wr_resp_valid); end
    v = port_cam_values[17*4 +: 17];
    checks++; if (v !== 17'h1_1234) begin errors++; $display("FAIL sop_cam4: got %h expected 11234", v); end
    tick();
  endtask

  task automatic test_reset_mid();
    beat(5, 1'b0); tick(); mon_idle();
    request(5'd10, 1'b0, 34'h0_CAFE_0001);
    port_config_sel = 5'd4;           // holds a nonzero value from an earlier test
    tick(); cfg_wr_valid = 0;
    tick();                           // still waiting on tid 5
    #2; aresetn = 0; model_reset();
    #1;
    checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", cfg_wr_ready); end
    checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_resp: got %b expected 0", cfg_wr_resp_valid); end
    checks++; if (port_config_regs !== 34'h0) begin errors++; $display("FAIL rstmid_regs: got %h expected 0", port_config_regs); end
    checks++; if (port_cam_values !== 272'h0) begin errors++; $display("FAIL rstmid_cam: got %h expected 0", port_cam_values); end
    tick();
    aresetn = 1;
    for (int s = 0; s < 32; s++) begin
      port_config_sel = 5'(s);
      tick();
      checks++; if (cfg_wr_resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_resp_%0d: got %b expected 0", s, cfg_wr_resp_valid); end
      checks++; if (port_config_regs !== 34'h0) begin errors++; $display("FAIL rstmid_sel_%0d: got %h expected 0", s, port_config_regs); end
    end
    checks++; if (cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b expected 1", cfg_wr_ready); end
    request(5'd10, 1'b0, 34'h0_CAFE_0002);
    port_config_sel = 5'd10;
    tick(); cfg_wr_valid = 0;
    tick();
    checks++; if (cfg_wr_resp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight_cleared: got %b expected 1", cfg_wr_resp_valid); end
    checks++; if (port_config_regs !== 34'h0_CAFE_0002) begin errors++; $display("FAIL rstmid_rewrite: got %h expected cafe0002", port_config_regs); end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [4:0]  s;
    bit e_rdy;
    for (int i = 0; i < 400; i++) begin
      e_rdy = !m_pend && !m_resp;
      checks++; if (cfg_wr_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready_%0d: got %b expected %b", i, cfg_wr_ready, e_rdy); end
      checks++; if (cfg_wr_resp_valid !== m_resp) begin errors++; $display("FAIL rnd_resp_%0d: got %b expected %b", i, cfg_wr_resp_valid, m_resp); end
      checks++; if (cfg_wr_resp_forced !== (m_resp && m_forced)) begin errors++; $display("FAIL rnd_forced_%0d: got %b expected %b", i, cfg_wr_resp_forced, m_resp && m_forced); end
      checks++; if (port_config_regs !== m_table[port_config_sel]) begin errors++; $display("FAIL rnd_regs_%0d: got %h expected %h", i, port_config_regs, m_table[port_config_sel]); end
      checks++; if (port_cam_values !== cam_pack()) begin errors++; $display("FAIL rnd_cam_%0d: got %h expected %h", i, port_cam_values, cam_pack()); end
      mon_tvalid = 1'($urandom_range(0, 1));
      mon_tready = 1'($urandom_range(0, 1));
      mon_tlast  = ($urandom_range(0, 3) == 0);
      mon_tid    = 4'($urandom_range(0, 3));
      cfg_wr_valid = ($urandom_range(0, 2) == 0);
      s = 5'($urandom_range(0, 7));
      cfg_wr_sel  = s;
      cfg_wr_type = 1'($urandom_range(0, 1));
      r = {$urandom, $urandom};
      cfg_wr_data = r[33:0];
      port_config_sel = 5'($urandom_range(0, 7));
      tick();
    end
    mon_idle();
    cfg_wr_valid = 0;
  endtask

  initial begin
    aresetn = 0;
    mon_idle();
    cfg_wr_valid = 0; cfg_wr_sel = '0; cfg_wr_type = 0; cfg_wr_data = '0;
    port_config_sel = '0;
    model_reset();
    test_reset();
    test_unblocked();
    test_packet_block();
    test_other_id();
    test_timeout();
    test_sop_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
